// File: rtl/serial_logic_unit_pkg.sv
// Shared types and helpers for serial_logic_unit: op encoding, FSM states and
// the counter-width function.
package serial_logic_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int count_width(input int width, input int bits_per_cycle);
    int n;
    n = width / bits_per_cycle;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_logic_unit_bit_slice.sv
// One-bit combinational logic/adder cell; op 11 is a full adder when
// SERIAL_LOGIC_UNIT_ADD_EN is defined and NAND otherwise.
import serial_logic_unit_pkg::*;

module bit_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_t  op,
  output logic y,
  output logic cout
);

`ifndef SERIAL_LOGIC_UNIT_ADD_EN
  logic unused_cin;
  assign unused_cin = cin;
`endif

  always_comb begin
    y    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_ADD: begin
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
        y    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
`else
        y    = ~(a & b);
`endif
      end
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Multi-cycle bit-serial AND/OR/XOR/ADD unit with start/done handshake.
// Define SERIAL_LOGIC_UNIT_ADD_EN to build op 11 as ADD (otherwise NAND, carry=0).
import serial_logic_unit_pkg::*;

module serial_logic_unit #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = count_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t                    state_q;
  op_t                       op_q;
  logic [CW-1:0]             count_q;
  logic [WIDTH-1:0]          a_sr;
  logic [WIDTH-1:0]          b_sr;
  logic [WIDTH-1:0]          res_sr;
  logic [WIDTH-1:0]          res_next;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [BITS_PER_CYCLE:0]   c;
  logic                      carry_q;

`ifdef SERIAL_LOGIC_UNIT_ADD_EN
  assign c[0] = carry_q;
`else
  // Without ADD the chain only ever carries zero; the carry flop is dropped.
  assign c[0] = 1'b0;
  assign carry_q = 1'b0;
  logic unused_chain;
  assign unused_chain = c[BITS_PER_CYCLE];
`endif

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
    bit_slice u_slice (
      .a    (a_sr[i]),
      .b    (b_sr[i]),
      .cin  (c[i]),
      .op   (op_q),
      .y    (chunk[i]),
      .cout (c[i+1])
    );
  end

  // New chunk enters at the MSB end so the first chunk lands at bit 0 after N shifts.
  assign res_next = (res_sr >> BITS_PER_CYCLE) | (WIDTH'(chunk) << (WIDTH - BITS_PER_CYCLE));

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      count_q <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      y       <= '0;
      carry   <= 1'b0;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
      carry_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            op_q    <= op_t'(op);
            count_q <= '0;
            res_sr  <= '0;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
            carry_q <= 1'b0;
`endif
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr    <= a_sr >> BITS_PER_CYCLE;
          b_sr    <= b_sr >> BITS_PER_CYCLE;
          res_sr  <= res_next;
          count_q <= count_q + CW'(1);
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
          carry_q <= c[BITS_PER_CYCLE];
`endif
          if (count_q == LAST) begin
            y       <= res_next;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
            carry   <= (op_q == OP_ADD) ? c[BITS_PER_CYCLE] : 1'b0;
`else
            carry   <= 1'b0;
`endif
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench for serial_logic_unit: three configurations (16/1, 16/4, 2/1)
// checked every cycle against a timeline model, plus hand-computed literal results.
`timescale 1ns/1ps
module tb_serial_logic_unit;

`ifdef SERIAL_LOGIC_UNIT_ADD_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic        start_i [3];
  logic [1:0]  op_i    [3];
  logic [15:0] a_i     [3];
  logic [15:0] b_i     [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic        carry_o [3];
  logic [15:0] y_o     [3];
  logic [15:0] y16, y4;
  logic [1:0]  y2;

  int nn [3] = '{16, 4, 2};
  int ww [3] = '{16, 16, 2};

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_logic_unit #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_i[0]), .op(op_i[0]), .a(a_i[0]), .b(b_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .y(y16), .carry(carry_o[0]));

  serial_logic_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_i[1]), .op(op_i[1]), .a(a_i[1]), .b(b_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .y(y4), .carry(carry_o[1]));

  serial_logic_unit #(.WIDTH(2), .BITS_PER_CYCLE(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_i[2]), .op(op_i[2]), .a(a_i[2][1:0]), .b(b_i[2][1:0]),
    .busy(busy_o[2]), .done(done_o[2]), .y(y2), .carry(carry_o[2]));

  assign y_o[0] = y16;
  assign y_o[1] = y4;
  assign y_o[2] = {14'b0, y2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry, y} for a w-bit operation from plain arithmetic.
  function automatic logic [16:0] ref_op(int w, logic [1:0] o, logic [15:0] av, logic [15:0] bv);
    logic [16:0] mask, am, bm, r;
    mask = (17'd1 << w) - 17'd1;
    am = {1'b0, av} & mask;
    bm = {1'b0, bv} & mask;
    case (o)
      2'b00:   r = am & bm;
      2'b01:   r = am | bm;
      2'b10:   r = am ^ bm;
      default: r = ADD_EN ? (am + bm) : (~(am & bm) & mask);
    endcase
    return {r[w], r[15:0] & mask[15:0]};
  endfunction

  // Model: m_cnt is cycles since capture (-1 idle, N = done cycle).
  int          m_cnt [3] = '{-1, -1, -1};
  logic [16:0] m_res [3];
  logic [15:0] m_y   [3] = '{16'h0, 16'h0, 16'h0};
  logic        m_c   [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_cnt[d] = -1;
        m_y[d]   = 16'h0;
        m_c[d]   = 1'b0;
      end else if (m_cnt[d] >= 0 && m_cnt[d] < nn[d]) begin
        m_cnt[d]++;
        if (m_cnt[d] == nn[d]) begin
          m_y[d] = m_res[d][15:0];
          m_c[d] = m_res[d][16];
        end
      end else if (start_i[d]) begin
        m_cnt[d] = 0;
        m_res[d] = ref_op(ww[d], op_i[d], a_i[d], b_i[d]);
      end else begin
        m_cnt[d] = -1;
      end
    end
  end

  task automatic checkOutput(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("busy%0d", d),  32'(busy_o[d]),  32'(m_cnt[d] >= 0 && m_cnt[d] < nn[d]));
      checkOutput($sformatf("done%0d", d),  32'(done_o[d]),  32'(m_cnt[d] == nn[d]));
      checkOutput($sformatf("y%0d", d),     32'(y_o[d]),     32'(m_y[d]));
      checkOutput($sformatf("carry%0d", d), 32'(carry_o[d]), 32'(m_c[d]));
    end
  end

  // Called at a negedge; returns at the negedge after the capture edge with inputs scrambled.
  task automatic applyStimulus(int d, logic [1:0] o, logic [15:0] av, logic [15:0] bv);
    start_i[d] = 1'b1;
    op_i[d]    = o;
    a_i[d]     = av;
    b_i[d]     = bv;
    @(negedge clk);
    start_i[d] = 1'b0;
    op_i[d]    = ~o;
    a_i[d]     = ~av;
    b_i[d]     = bv ^ 16'h5A5A;
  endtask

  task automatic waitDone(int d, output int n, output int bc);
    n  = 0;
    bc = 0;
    while (!done_o[d] && n < 64) begin
      if (busy_o[d]) bc++;
      @(negedge clk);
      n++;
    end
    if (!done_o[d]) checkOutput($sformatf("done_timeout%0d", d), 32'(done_o[d]), 32'd1);
  endtask

  task automatic runOp(string nm, int d, logic [1:0] o, logic [15:0] av, logic [15:0] bv,
                       logic [15:0] ey, logic ec);
    int lat, bc;
    applyStimulus(d, o, av, bv);
    waitDone(d, lat, bc);
    checkOutput({nm, "_y"},       32'(y_o[d]),     32'(ey));
    checkOutput({nm, "_carry"},   32'(carry_o[d]), 32'(ec));
    checkOutput({nm, "_latency"}, 32'(lat),        32'(nn[d]));
    checkOutput({nm, "_busy"},    32'(bc),         32'(nn[d]));
  endtask

  initial begin
    int n, bc, seen;
    logic [16:0] r;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_i[d] = 1'b0; op_i[d] = 2'b00; a_i[d] = 16'h0; b_i[d] = 16'h0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset_y",     32'(y_o[0]),     32'h0);
    checkOutput("reset_busy",  32'(busy_o[0]),  32'h0);
    checkOutput("reset_done",  32'(done_o[0]),  32'h0);
    checkOutput("reset_carry", 32'(carry_o[0]), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    runOp("and16", 0, 2'b00, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0);
    runOp("add_wrap16", 0, 2'b11, 16'hFFFF, 16'h0001, ADD_EN ? 16'h0000 : 16'hFFFE, ADD_EN);
    runOp("add16", 0, 2'b11, 16'h1234, 16'h0FF0, ADD_EN ? 16'h2224 : 16'hFDCF, 1'b0);
    runOp("op3_16", 0, 2'b11, 16'hF0F0, 16'hFF00, ADD_EN ? 16'hEFF0 : 16'h0FFF, ADD_EN);
    runOp("xor4", 1, 2'b10, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0);

    // start during RUN is ignored; the OR result must come back
    applyStimulus(0, 2'b01, 16'h00F0, 16'h0F00);
    repeat (2) @(negedge clk);
    start_i[0] = 1'b1; op_i[0] = 2'b00; a_i[0] = 16'hFFFF; b_i[0] = 16'h0000;
    @(negedge clk);
    start_i[0] = 1'b0;
    waitDone(0, n, bc);
    checkOutput("ignored_start_y", 32'(y_o[0]), 32'h0FF0);

    // back-to-back: start issued during the DONE cycle
    runOp("b2b_xor", 0, 2'b10, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0);

    // reset at RUN cycle 5
    applyStimulus(0, 2'b00, 16'h1234, 16'h5678);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_y",    32'(y_o[0]),    32'h0);
    checkOutput("abort_busy", 32'(busy_o[0]), 32'h0);
    checkOutput("abort_done", 32'(done_o[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o[0]) seen++;
    end
    checkOutput("abort_no_done", 32'(seen), 32'd0);
    runOp("restart_and", 0, 2'b00, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0);

    runOp("add2_wrap", 2, 2'b11, 16'h0003, 16'h0001, ADD_EN ? 16'h0000 : 16'h0002, ADD_EN);
    for (int o = 0; o < 4; o++)
      for (int av = 0; av < 4; av++)
        for (int bv = 0; bv < 4; bv++) begin
          r = ref_op(2, 2'(o), 16'(av), 16'(bv));
          runOp($sformatf("w2_op%0d_%0d_%0d", o, av, bv), 2, 2'(o), 16'(av), 16'(bv),
                r[15:0], r[16]);
        end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_logic_unit.md
# serial_logic_unit

Parametrised multi-cycle successor to the 1-bit logic gates: applies AND, OR, XOR or ADD to two WIDTH-bit operands, processing BITS_PER_CYCLE bits per clock through a shared 1-bit slice. It sits between the basic gate library and the future ALU as a start/done-handshaked datapath unit. Results are held stable until the next operation completes.

## Interface
- WIDTH, 16: operand and result width; must be at least 2.
- BITS_PER_CYCLE, 1: bits processed per cycle; must divide WIDTH. N = WIDTH/BITS_PER_CYCLE.
- clk  in  1  single clock; all state updates occur on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  request; sampled on rising edges.
- op  in  2  00 AND, 01 OR, 10 XOR, 11 ADD (NAND when ADD is compiled out).
- a  in  WIDTH  operand A, captured with start.
- b  in  WIDTH  operand B, captured with start.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; y and carry are valid while it is high.
- y  out  WIDTH  result register.
- carry  out  1  ADD carry-out; 0 for all other ops.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Values while rst is high: busy=0, done=0, y=0, carry=0. Internal shift registers and count are 0.
- IDLE or DONE with start=1:
  - Capture a, b and op into internal registers.
  - Clear count, the internal carry and the result shift register.
  - Go to RUN.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - Feed the BITS_PER_CYCLE LSBs of the A and B shift registers through the slice chain. The slice carry ripples LSB to MSB within the chunk; the internal carry flop links chunks.
  - Shift the operands right by BITS_PER_CYCLE.
  - Shift the result chunk into the result register from the MSB end.
  - Increment count.
- RUN with count == N-1 on an edge: write the completed result to y and the final carry to carry (0 unless op is ADD), then go to DONE.
- start is ignored while in RUN. No queueing. Inputs a, b and op may change freely after capture.
- ADD: sum is modulo 2^WIDTH; overflow appears only on carry.
- y and carry change only on a completion edge or on reset.

## Timing
- The capture edge is edge 0. busy is high from edge 0 until edge N. done is high for exactly the cycle after edge N.
- Latency: N cycles from capture to done.
- Back-to-back: start high during the DONE cycle is accepted, giving a throughput of one result per N+1 cycles.
- Reset mid-RUN: all outputs clear immediately (asynchronously), with no done pulse. The first start after rst is released restarts cleanly.
- busy and done are decoded directly from the state register, so neither has a combinational path from any input.

## Configuration
- SERIAL_LOGIC_UNIT_ADD_EN defined:
  - op 11 performs ADD.
  - The carry flop and the slice carry chain are present.
- SERIAL_LOGIC_UNIT_ADD_EN undefined:
  - op 11 performs bitwise NAND.
  - The carry flop is removed and the carry output is tied to 0.
  - Latency and handshake are unchanged.

## Structure
- Package serial_logic_unit_pkg holds:
  - the op encoding typedef (OP_AND, OP_OR, OP_XOR, OP_ADD);
  - the state typedef (ST_IDLE, ST_RUN, ST_DONE);
  - the count width function, clog2 of N.
- Sub-module bit_slice: 1-bit combinational cell with inputs a, b, cin and op, and outputs y and cout. BITS_PER_CYCLE instances are chained.
- The top level contains the FSM, the counter, the operand/result shift registers and the output registers.

## Test plan
- WIDTH=16, BITS_PER_CYCLE=1, AND, a=0xF0F0, b=0xFF00:
  - y=0xF000 and carry=0 when done pulses.
  - done arrives 16 cycles after capture; busy is high for 16 cycles.
- ADD, a=0xFFFF, b=0x0001 -> y=0x0000, carry=1. ADD 0x1234+0x0FF0 -> y=0x2224, carry=0.
- BITS_PER_CYCLE=4, XOR, a=0x1234, b=0xFFFF -> y=0xEDCB, done 4 cycles after capture.
- Abort and back-to-back, in sequence:
  - Assert start again during RUN with different operands; it must be ignored and the first result returned.
  - Assert start during the DONE cycle; the new op is captured.
  - Assert rst at RUN cycle 5; y=0, busy=0, done=0 immediately and no done pulse follows.
- Macro undefined, op=11, a=0xF0F0, b=0xFF00 -> y=0x0FFF, carry=0.
- Exhaustive 1-bit check with WIDTH=2, all ops and all operand pairs, compared against the bitwise/arith reference. Include the 2-bit ADD wrap 3+1 -> 0 with carry=1.
